// File: rtl/rgb_frame_writer_pkg.sv
// Shared types and sizes for the RGB frame writer.
// Pixels are 48-bit {red, green, blue}; memory words are 64 bits.
package rgb_writer_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int WORD_W     = 64;
  localparam int PIX_W      = 48;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] ONE_CNT   = (PTR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef logic [PIX_W-1:0] pix_t;

  function automatic logic [WORD_W-1:0] pack_word(pix_t p);
    return {16'h0000, p};
  endfunction

endpackage

// File: rtl/rgb_frame_writer_if.sv
// Push/pop bundle between the frame writer and its pixel FIFO.
// master = writer side, slave = FIFO side.
interface rgb_frame_writer_if;
  import rgb_writer_pkg::*;

  logic           push;
  logic           pop;
  pix_t           din;
  pix_t           head;
  logic           full;
  logic           empty;
  logic [PTR_W:0] cnt;

  modport master (
    output push, pop, din,
    input  head, full, empty, cnt
  );

  modport slave (
    input  push, pop, din,
    output head, full, empty, cnt
  );

endinterface

// File: rtl/rgb_frame_writer_pixel_fifo.sv
// 4-deep, 48-bit synchronous FIFO with first-word head output.
// A push on a full FIFO is taken when a pop completes in the same cycle.
module pixel_fifo
  import rgb_writer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  rgb_frame_writer_if.slave  f
);

  pix_t             mem_q [FIFO_DEPTH];
  pix_t             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop  = f.pop && (cnt_q != '0);
    do_push = f.push && ((cnt_q != DEPTH_CNT) || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = f.din;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign f.head  = mem_q[rd_q];
  assign f.full  = (cnt_q == DEPTH_CNT);
  assign f.empty = (cnt_q == '0);
  assign f.cnt   = cnt_q;

endmodule

// File: rtl/rgb_frame_writer.sv
// Buffers demosaiced RGB pixels and writes one 64-bit word per pixel
// to consecutive word addresses starting at base_adr.
module rgb_frame_writer
  import rgb_writer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] FWIDTH,
  input  logic [15:0] FHEIGHT,
  input  logic [31:0] base_adr,
  input  logic        start,
  input  logic        data_v,
  input  logic [15:0] red,
  input  logic [15:0] green,
  input  logic [15:0] blue,
  input  logic        mem_ready,
  output logic        mem_write,
  output logic [31:0] adr,
  output logic [63:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] total_q, total_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] idx_q, idx_d;
  logic        ovf_q, ovf_d;

  logic        active;
  logic        wr;
  logic        pop;
  logic        push;
  logic        drop;
  logic        drained;
  logic [31:0] total;

  rgb_frame_writer_if fif ();

  pixel_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .f     (fif)
  );

  always_comb begin
    active  = (state_q == S_RUN) || (state_q == S_DRAIN);
    wr      = active && !fif.empty;
    pop     = wr && mem_ready;
    push    = (state_q == S_RUN) && data_v && (!fif.full || pop);
    drop    = (state_q == S_RUN) && data_v && fif.full && !pop;
    // Empty after this cycle's pop, so done follows the last write directly.
    drained = fif.empty || (pop && (fif.cnt == ONE_CNT));
    total   = {16'h0000, FWIDTH} * {16'h0000, FHEIGHT};

    state_d = state_q;
    base_d  = base_q;
    total_d = total_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_adr;
          total_d = total;
          acc_d   = '0;
          idx_d   = '0;
          ovf_d   = 1'b0;
          if ((FWIDTH == '0) || (FHEIGHT == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (push) begin
          acc_d = acc_q + 32'd1;
        end
        if (acc_d == total_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drained) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (pop) begin
      idx_d = idx_q + 32'd1;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      total_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      total_q <= total_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign fif.push = push;
  assign fif.pop  = pop;
  assign fif.din  = {red, green, blue};

  assign mem_write = wr;
  assign adr       = wr ? (base_q + idx_q) : '0;
  assign wdata     = wr ? pack_word(fif.head) : '0;
  assign busy      = active;
  assign done      = (state_q == S_DONE);
  assign overflow  = ovf_q;

endmodule

// File: doc/rgb_frame_writer.md
RGB_FRAME_WRITER -- requirements
Module: rgb_frame_writer

Interface
REQ-001 SHALL have ports clk, in, 1, the single clock; all logic on its rising edge.
REQ-002 SHALL have ports reset, in, 1; one clock; reset is synchronous and active-low (reset==0 resets on the clk edge).
REQ-003 SHALL have ports FWIDTH, in, 16, frame width in pixels; sampled at start.
REQ-004 SHALL have ports FHEIGHT, in, 16, frame height in pixels; sampled at start.
REQ-005 SHALL have ports base_adr, in, 32, first output word address; sampled at start.
REQ-006 SHALL have ports start, in, 1, one-cycle frame-start request.
REQ-007 SHALL have ports data_v, in, 1, pixel valid from the demosaic stream.
REQ-008 SHALL have ports red / green / blue, in, 16 each, pixel components, qualified by data_v.
REQ-009 SHALL have ports mem_ready, in, 1, memory accepts the write this cycle.
REQ-010 SHALL have ports mem_write, out, 1, write request.
REQ-011 SHALL have ports adr, out, 32, write word address.
REQ-012 SHALL have ports wdata, out, 64, write data.
REQ-013 SHALL have ports busy, out, 1, high in RUN or DRAIN.
REQ-014 SHALL have ports done, out, 1, one-cycle end-of-frame pulse.
REQ-015 SHALL have ports overflow, out, 1, sticky pixel-drop flag.

Function
REQ-016 SHALL use FSM states IDLE, RUN, DRAIN, DONE. Transitions: IDLE->RUN on start; RUN->DRAIN when accepted count == FWIDTH*FHEIGHT; DRAIN->DONE when FIFO empty; DONE->IDLE unconditionally after 1 cycle.
REQ-017 SHALL go IDLE->DONE directly on start when the sampled FWIDTH==0 or FHEIGHT==0, with no writes.
REQ-018 SHALL clear overflow and the pixel/address counters on start in IDLE; SHALL ignore start outside IDLE.
REQ-019 SHALL push a pixel into a 4-entry FIFO only in RUN with data_v=1; SHALL ignore data_v in IDLE, DRAIN and DONE.
REQ-020 SHALL pack wdata as {16'h0000, red, green, blue} (bits 63:48 zero, 47:32 red, 31:16 green, 15:0 blue).
REQ-021 SHALL assert mem_write whenever the FIFO is non-empty in RUN or DRAIN; latency from data_v to first mem_write is exactly 1 cycle.
REQ-022 SHALL complete a write on a cycle with mem_write && mem_ready: pop the FIFO and increment the output pixel index.
REQ-023 SHALL hold adr and wdata stable while mem_write=1 and mem_ready=0.
REQ-024 SHALL drive adr = base_adr + row*FWIDTH + col for the pixel at the FIFO head, which is base_adr + output pixel index. col wraps to 0 at FWIDTH-1 and row increments on that wrap. Arithmetic is 32-bit modulo 2^32.
REQ-025 SHALL accept a push on a full FIFO when a pop completes in the same cycle.
REQ-026 SHALL, on data_v in RUN with the FIFO full and no pop, drop the pixel, not count it, and set overflow=1 until the next start.
REQ-027 SHALL assert done=1 only in DONE, for exactly one cycle.
REQ-028 SHALL use a 32-bit accepted-pixel counter; the FWIDTH*FHEIGHT product is formed 32 bits wide.

Reset
REQ-029 SHALL, on reset==0 at a clk edge, set state=IDLE, FIFO empty, all counters 0, mem_write=0, adr=0, wdata=0, busy=0, done=0, overflow=0, regardless of state; an in-flight frame is abandoned.

Structure
REQ-030 SHALL place the state enum, FIFO_DEPTH=4 and WORD_W=64 in shared package rgb_writer_pkg.
REQ-031 SHALL instantiate one sub-module, pixel_fifo: a 48-bit-wide, 4-deep synchronous FIFO with push, pop, full, empty and head output.

Verification
REQ-032 SHALL cover: FWIDTH=4, FHEIGHT=2, base_adr=0x20000, mem_ready=1, 8 consecutive pixels -> 8 writes to adr 0x20000..0x20007 in order, each 1 cycle after its data_v; done pulses 1 cycle after the last write.
REQ-033 SHALL cover: first pixel red=0x1111, green=0x2222, blue=0x3333 -> wdata=0x0000111122223333.
REQ-034 SHALL cover: mem_ready=0 for 3 cycles during a write -> mem_write, adr and wdata constant for those cycles; write completes on the 4th cycle.
REQ-035 SHALL cover: mem_ready=0 and 5 pixels pushed -> 4 pixels stored, overflow=1; after mem_ready=1 exactly 4 writes occur and the FSM stays in RUN awaiting the remaining pixels.
REQ-036 SHALL cover: start with FHEIGHT=0 -> done on the next cycle, mem_write never asserted.
REQ-037 SHALL cover: reset=0 mid-frame after 3 writes -> all outputs 0 next cycle; a new start with base_adr=0x30000 writes from 0x30000.
